// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch/decode/execute/writeback,
// with optional memory handshake stalls and optional trap on illegal instructions.
module mc_controller #(
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       mem_ready,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [3:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Illegal,
  output logic       Retire
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001;

  state_t state_r, state_next_s;
  logic mem_ok_s;
  logic ir_write_s, pc_write_s, reg_write_s, mem_write_s, illegal_s, retire_s;
  state_t bad_next_s;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic op5, input logic f7);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (op5 && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  code = 4'b0110;
      3'b010:  code = 4'b0101;
      3'b011:  code = 4'b1001;
      3'b100:  code = 4'b0100;
      3'b101:  code = f7 ? 4'b1000 : 4'b0111;
      3'b110:  code = 4'b0011;
      3'b111:  code = 4'b0010;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    logic tk;
    case (f3)
      3'b000:  tk = z;
      3'b001:  tk = !z;
      3'b100:  tk = lt;
      3'b101:  tk = !lt;
      3'b110:  tk = ltu;
      3'b111:  tk = !ltu;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  assign mem_ok_s   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign bad_next_s = ILLEGAL_TRAP ? S_TRAP : S_FETCH;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_FETCH;
    else        state_r <= state_next_s;
  end

  // Next-state and datapath controls, decoded from the current state.
  always_comb begin
    state_next_s = state_r;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    AdrSrc       = 1'b0;
    ALUControl   = ALU_ADD;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    illegal_s    = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_s = mem_ok_s;
        pc_write_s = mem_ok_s;
        if (mem_ok_s) state_next_s = S_DECODE;
        else          state_next_s = S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_R:         state_next_s = S_EXECR;
          OP_I:         state_next_s = S_EXECI;
          OP_BR:        state_next_s = (funct3 == 3'b010 || funct3 == 3'b011) ? bad_next_s : S_BRANCH;
          OP_JAL:       state_next_s = S_JAL;
          OP_JALR:      state_next_s = S_JALR1;
          OP_LUI:       state_next_s = S_LUI;
          OP_AUIPC:     state_next_s = S_AUIPC;
          default:      state_next_s = bad_next_s;
        endcase
      end
      S_MEMADR, S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (state_r == S_JALR1)  state_next_s = S_JALR2;
        else if (op == OP_LW)    state_next_s = S_MEMREAD;
        else                     state_next_s = S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ok_s) state_next_s = S_MEMWB;
        else          state_next_s = S_MEMREAD;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = mem_ok_s;
        retire_s    = mem_ok_s;
        if (mem_ok_s) state_next_s = S_FETCH;
        else          state_next_s = S_MEMWRITE;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_next_s = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = (state_r == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl   = alu_decode(funct3, op[5], funct7b5);
        state_next_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUControl   = ALU_SUB;
        pc_write_s   = branch_taken(funct3, Zero, Lt, Ltu);
        retire_s     = 1'b1;
        state_next_s = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_s   = 1'b1;
        state_next_s = S_ALUWB;
      end
      S_LUI, S_AUIPC: begin
        ALUSrcA      = (state_r == S_LUI) ? 2'b11 : 2'b01;
        ALUSrcB      = 2'b01;
        state_next_s = S_ALUWB;
      end
      S_TRAP: begin
        illegal_s    = 1'b1;
        state_next_s = S_TRAP;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (op)
      OP_LW, OP_I, OP_JALR: ImmSrc = 3'b000;
      OP_SW:                ImmSrc = 3'b001;
      OP_BR:                ImmSrc = 3'b010;
      OP_JAL:               ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:     ImmSrc = 3'b100;
      default:              ImmSrc = 3'b000;
    endcase
  end

  // Reset gates the enables combinationally so they drop without waiting for a clock.
  assign IRWrite  = reset & ir_write_s;
  assign PCWrite  = reset & pc_write_s;
  assign RegWrite = reset & reg_write_s;
  assign MemWrite = reset & mem_write_s;
  assign Illegal  = reset & illegal_s;
  assign Retire   = reset & retire_s;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected cycle sequences built from the
// instruction-level rules, compared cycle by cycle against two parameterisations.
module tb_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, funct7b5, Zero, Lt, Ltu, mem_ready, sel;
  logic [6:0] op;
  logic [2:0] funct3;

  logic [2:0] a_imm, b_imm;
  logic [1:0] a_asa, a_asb, a_rs, b_asa, b_asb, b_rs;
  logic [3:0] a_alu, b_alu;
  logic a_adr, a_ir, a_pc, a_rw, a_mw, a_ill, a_ret;
  logic b_adr, b_ir, b_pc, b_rw, b_mw, b_ill, b_ret;

  mc_controller #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_TRAP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .ImmSrc(a_imm), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ResultSrc(a_rs), .AdrSrc(a_adr),
    .ALUControl(a_alu), .IRWrite(a_ir), .PCWrite(a_pc), .RegWrite(a_rw), .MemWrite(a_mw),
    .Illegal(a_ill), .Retire(a_ret));

  mc_controller #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .ImmSrc(b_imm), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ResultSrc(b_rs), .AdrSrc(b_adr),
    .ALUControl(b_alu), .IRWrite(b_ir), .PCWrite(b_pc), .RegWrite(b_rw), .MemWrite(b_mw),
    .Illegal(b_ill), .Retire(b_ret));

  logic [5:0] o_en;
  logic [2:0] o_imm;
  logic [1:0] o_asa, o_asb, o_rs;
  logic [3:0] o_alu;
  logic       o_adr;
  assign o_en  = sel ? {b_ir, b_pc, b_rw, b_mw, b_ill, b_ret} : {a_ir, a_pc, a_rw, a_mw, a_ill, a_ret};
  assign o_imm = sel ? b_imm : a_imm;
  assign o_asa = sel ? b_asa : a_asa;
  assign o_asb = sel ? b_asb : a_asb;
  assign o_rs  = sel ? b_rs  : a_rs;
  assign o_alu = sel ? b_alu : a_alu;
  assign o_adr = sel ? b_adr : a_adr;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001;

  // en = {IRWrite, PCWrite, RegWrite, MemWrite, Illegal, Retire}; ck = {adr, rs, asb, asa} checked
  typedef struct {
    logic       rdy;
    logic [5:0] en;
    logic [1:0] asa, asb, rs;
    logic       adr;
    logic [3:0] alu;
    logic [3:0] ck;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  bit   hs, trap, ends_trap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    if (o == OP_SW) return 3'b001;
    if (o == OP_BR) return 3'b010;
    if (o == OP_JAL) return 3'b011;
    if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [3:0] tbl [8];
    tbl = '{ADD, 4'b0110, 4'b0101, 4'b1001, 4'b0100, 4'b0111, 4'b0011, 4'b0010};
    if (f3 == 3'd0 && is_r && f7) return SUB;
    if (f3 == 3'd5 && f7) return 4'b1000;
    return tbl[f3];
  endfunction

  task automatic push(input logic rdy, input logic [5:0] en, input logic [1:0] asa, asb, rs,
                      input logic adr, input logic [3:0] alu, input logic [3:0] ck);
    exp_t e;
    e.rdy = rdy; e.en = en; e.asa = asa; e.asb = asb; e.rs = rs;
    e.adr = adr; e.alu = alu; e.ck = ck;
    exp_q.push_back(e);
  endtask

  // A memory-facing cycle: with the handshake, stall cycles with no enables, then the ready cycle.
  task automatic push_wait(input int stalls, input logic [5:0] en, input logic [1:0] asa, asb, rs,
                           input logic adr, input logic [3:0] ck);
    int n;
    if (hs) begin
      n = (stalls < 0) ? int'($urandom_range(0, 3)) : stalls;
      repeat (n) push(1'b0, 6'b0, asa, asb, rs, adr, ADD, ck);
      push(1'b1, en, asa, asb, rs, adr, ADD, ck);
    end else begin
      push(rb(), en, asa, asb, rs, adr, ADD, ck);
    end
  endtask

  task automatic aluwb();
    push(rb(), 6'b001001, 2'b00, 2'b00, 2'b00, 1'b0, ADD, 4'b0100);
  endtask

  task automatic illegal_tail();
    if (trap) begin
      repeat (3) push(rb(), 6'b000010, 2'b00, 2'b00, 2'b00, 1'b0, ADD, 4'b0000);
      ends_trap = 1'b1;
    end else begin
      ends_trap = 1'b0;
    end
  endtask

  task automatic gen(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, lt, ltu, input int fs, ms);
    logic tk;
    tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? lt :
         (f3 == 3'd5) ? !lt : (f3 == 3'd6) ? ltu : !ltu;
    push_wait(fs, 6'b110000, 2'b00, 2'b10, 2'b10, 1'b0, 4'b1111);
    push(rb(), 6'b0, 2'b01, 2'b01, 2'b00, 1'b0, ADD, 4'b0011);
    case (o)
      OP_LW: begin
        push(rb(), 6'b0, 2'b10, 2'b01, 2'b00, 1'b0, ADD, 4'b0011);
        push_wait(ms, 6'b0, 2'b00, 2'b00, 2'b00, 1'b1, 4'b1100);
        push(rb(), 6'b001001, 2'b00, 2'b00, 2'b01, 1'b0, ADD, 4'b0100);
      end
      OP_SW: begin
        push(rb(), 6'b0, 2'b10, 2'b01, 2'b00, 1'b0, ADD, 4'b0011);
        push_wait(ms, 6'b000101, 2'b00, 2'b00, 2'b00, 1'b1, 4'b1100);
      end
      OP_R:  begin push(rb(), 6'b0, 2'b10, 2'b00, 2'b00, 1'b0, alu_ref(f3, f7, 1'b1), 4'b0011); aluwb(); end
      OP_I:  begin push(rb(), 6'b0, 2'b10, 2'b01, 2'b00, 1'b0, alu_ref(f3, f7, 1'b0), 4'b0011); aluwb(); end
      OP_BR: begin
        if (f3 == 3'd2 || f3 == 3'd3) illegal_tail();
        else push(rb(), {1'b0, tk, 4'b0001}, 2'b10, 2'b00, 2'b00, 1'b0, SUB, 4'b0111);
      end
      OP_JAL: begin push(rb(), 6'b010000, 2'b01, 2'b10, 2'b00, 1'b0, ADD, 4'b0111); aluwb(); end
      OP_JALR: begin
        push(rb(), 6'b0, 2'b10, 2'b01, 2'b00, 1'b0, ADD, 4'b0011);
        push(rb(), 6'b010000, 2'b01, 2'b10, 2'b00, 1'b0, ADD, 4'b0111);
        aluwb();
      end
      OP_LUI:   begin push(rb(), 6'b0, 2'b11, 2'b01, 2'b00, 1'b0, ADD, 4'b0011); aluwb(); end
      OP_AUIPC: begin push(rb(), 6'b0, 2'b01, 2'b01, 2'b00, 1'b0, ADD, 4'b0011); aluwb(); end
      default: illegal_tail();
    endcase
  endtask

  // Assert reset between edges, check the forced outputs, then release just after a rising edge.
  task automatic rst_mid();
    reset = 1'b0;
    #1;
    chk("rst_en", o_en, 6'b0);
    chk("rst_asa", o_asa, 2'b00);
    chk("rst_asb", o_asb, 2'b10);
    chk("rst_rs", o_rs, 2'b10);
    chk("rst_adr", o_adr, 1'b0);
    chk("rst_alu", o_alu, ADD);
    @(posedge clk);
    #1 chk("rst_en_hold", o_en, 6'b0);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, lt, ltu, input int fs, ms, abort_idx);
    exp_t e;
    exp_q.delete();
    ends_trap = 1'b0;
    gen(o, f3, f7, z, lt, ltu, fs, ms);
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      @(negedge clk);
      if (i == 0) begin
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; Lt = lt; Ltu = ltu;
      end
      mem_ready = e.rdy;
      #1;
      chk($sformatf("en op=%0h f3=%0d cyc=%0d", o, f3, i), o_en, e.en);
      chk($sformatf("imm op=%0h", o), o_imm, imm_ref(o));
      chk($sformatf("alu op=%0h f3=%0d f7=%0d cyc=%0d", o, f3, f7, i), o_alu, e.alu);
      if (e.ck[0]) chk($sformatf("asa op=%0h cyc=%0d", o, i), o_asa, e.asa);
      if (e.ck[1]) chk($sformatf("asb op=%0h cyc=%0d", o, i), o_asb, e.asb);
      if (e.ck[2]) chk($sformatf("rs op=%0h cyc=%0d", o, i), o_rs, e.rs);
      if (e.ck[3]) chk($sformatf("adr op=%0h cyc=%0d", o, i), o_adr, e.adr);
      if (i == abort_idx) begin
        rst_mid();
        return;
      end
    end
    if (ends_trap) rst_mid();
  endtask

  task automatic run_random(input int n);
    logic [6:0] legal [9];
    logic [6:0] bad [4];
    int k;
    legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    bad   = '{7'b1111111, 7'b0000000, 7'b0001111, 7'b1110011};
    for (int j = 0; j < n; j++) begin
      k = int'($urandom_range(0, 9));
      run((k == 9) ? bad[$urandom_range(0, 3)] : legal[k], 3'($urandom_range(0, 7)),
          rb(), rb(), rb(), rb(), -1, -1, -1);
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; hs = 1'b0; trap = 1'b1;
    op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; mem_ready = 1'b0;
    #1 rst_mid();

    // Single-cycle memory, trapping configuration.
    run(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    run(OP_R, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    run(OP_BR, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    run(OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    run(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    run(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    run(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 3);
    run(OP_I, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    run_random(40);

    // Handshaked memory, illegal-as-NOP configuration.
    sel = 1'b1; hs = 1'b1; trap = 1'b0;
    @(negedge clk);
    #1 rst_mid();
    run(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2, -1);
    run(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1, -1);
    run(OP_BR, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    run(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, -1);
    run_random(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 0: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored, single-cycle memory.
REQ-002 SHALL have parameter ILLEGAL_TRAP, default 1: 1 = illegal instruction enters TRAP; 0 = treated as NOP and execution returns to FETCH.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero, Lt, Ltu  in  1 each  ALU flags: equal, signed less-than, unsigned less-than of SrcA-SrcB.
- mem_ready  in  1  memory access completes this cycle.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- AdrSrc  out  1  0 PC, 1 Result.
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu.
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write enables.
- Illegal  out  1  high while in TRAP.
- Retire  out  1  one-cycle pulse on final cycle of each completed instruction.

Function
REQ-004 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC, TRAP.
REQ-005 SHALL decode in DECODE: lw 0000011, sw 0100011 -> MEMADR; R 0110011 -> EXECR; I-ALU 0010011 -> EXECI; branch 1100011 -> BRANCH; jal 1101111 -> JAL; jalr 1100111 -> JALR1; lui 0110111 -> LUI; auipc 0010111 -> AUIPC; any other opcode, or branch funct3 010/011 -> illegal.
REQ-006 SHALL use these transitions: MEMADR -> MEMREAD (lw) or MEMWRITE (sw); MEMREAD -> MEMWB; EXECR, EXECI, JAL, JALR2, LUI, AUIPC -> ALUWB; JALR1 -> JALR2; MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH; TRAP -> TRAP.
REQ-007 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1.
REQ-008 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add, so that OldPC+imm is captured in ALUOut.
REQ-009 The remaining states SHALL drive:
- MEMADR: rs1+imm.
- MEMREAD / MEMWRITE: AdrSrc=1, ResultSrc=00; MemWrite=1 in MEMWRITE.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECR: rs1 op rs2.
- EXECI: rs1 op imm.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: OldPC+4, ResultSrc=00, PCWrite=1.
- JALR1: rs1+imm.
- JALR2: OldPC+4, ResultSrc=00, PCWrite=1.
- LUI: zero+imm.
- AUIPC: OldPC+imm.
REQ-010 BRANCH SHALL drive rs1-rs2 (sub), ResultSrc=00, and PCWrite = taken, where taken by funct3 is: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu.
REQ-011 ALUControl in EXECR/EXECI SHALL decode funct3 as 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
- sub only when op[5]=1 and funct7b5=1; sra when funct7b5=1.
- All other states use add, except BRANCH, which uses sub.
REQ-012 ImmSrc SHALL be combinational from op in every state: I for lw/I-ALU/jalr, S for sw, B for branch, J for jal, U for lui/auipc, 000 otherwise.
REQ-013 With MEM_HANDSHAKE=1, FETCH, MEMREAD and MEMWRITE SHALL hold while mem_ready=0.
- During the hold, IRWrite, PCWrite and MemWrite are 0.
- The enables assert only in the cycle mem_ready=1, and the state advances on that edge.
REQ-014 Retire SHALL pulse in the last cycle of MEMWB, MEMWRITE (qualified by mem_ready when MEM_HANDSHAKE=1), ALUWB and BRANCH; it SHALL never pulse for an illegal instruction.
REQ-015 On an illegal instruction, DECODE SHALL go to TRAP when ILLEGAL_TRAP=1 (Illegal=1, all write enables 0), or to FETCH with no writes when ILLEGAL_TRAP=0.
REQ-016 Write enables SHALL be 0 in any state not listed as asserting them.

Reset
REQ-017 reset=0 SHALL force state FETCH immediately, independent of clk.
REQ-018 While reset=0, IRWrite, PCWrite, RegWrite, MemWrite, Illegal and Retire SHALL be 0; other outputs take their FETCH values.
REQ-019 Reset asserted mid-instruction (including during a mem_ready stall or in TRAP) SHALL abandon the instruction with no further writes.
REQ-020 The first rising clk edge after reset deasserts SHALL begin a normal FETCH.

Verification
REQ-021 add (op=0110011, funct3=000, funct7b5=0): FETCH, DECODE, EXECR (ALUControl=0000), ALUWB (RegWrite=1, Retire=1), then FETCH -- 4 cycles.
REQ-022 bne (funct3=001) with Zero=0: PCWrite=1 in BRANCH. With Zero=1: PCWrite=0. Both cases: Retire=1, next state FETCH.
REQ-023 jalr (op=1100111): JALR1 (ALUSrcA=10, ALUSrcB=01), JALR2 (PCWrite=1, ResultSrc=00), ALUWB (RegWrite=1) -- 5 cycles total.
REQ-024 MEM_HANDSHAKE=1, lw with mem_ready low 3 cycles in FETCH and 2 cycles in MEMREAD: IRWrite/PCWrite=0 during the stall, asserted only on the ready cycle; total 5+5=10 cycles; RegWrite=1 once.
REQ-025 op=1111111 with ILLEGAL_TRAP=1: Illegal=1 from the cycle after DECODE and held; no write enables; reset pulse low returns to FETCH with Illegal=0. With ILLEGAL_TRAP=0: FETCH follows DECODE, Retire stays 0.
REQ-026 Async reset: drive reset=0 between clock edges during MEMWRITE: MemWrite drops to 0 before the next edge, and the state is FETCH after release.
